// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction-fetch stage
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus_4;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous queue of fetched entries with flush
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   output fetch_entry_t       head,
   output logic [CNT_W-1:0]   count,
   output logic               empty,
   output logic               full
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty && !clear;
   // the caller guarantees space, so a push while full always pairs with a pop
   assign do_push = push && !clear;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, credit-limited imem requester and fetch queue feeding decode
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        e_pc_src,
   input  logic [31:0] e_pc_target,
   input  logic        f_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        f_valid,
   output logic [31:0] f_pc,
   output logic [31:0] f_pc_plus_4,
   output logic [31:0] f_instruction
);

   localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int          SUM_W      = CNT_W + 1;
   localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

   logic [31:0]      fetch_pc;
   logic [31:0]      resp_pc;
   logic [31:0]      target_w;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] q_count;
   logic [SUM_W-1:0] in_use;
   logic             q_empty;
   logic             q_full;
   logic             q_push;
   logic             q_pop;
   logic             handshake;
   fetch_entry_t     q_head;
   fetch_entry_t     q_push_data;

   assign target_w = e_pc_target & ~32'd3;
   assign q_pop    = !q_empty && !f_stall && !e_pc_src;

   // a slot popped this cycle is free before any new response can land in it
   assign in_use    = SUM_W'(outstanding) + SUM_W'(q_count) - SUM_W'(q_pop);
   assign imem_req  = reset_n && !e_pc_src && (in_use < SUM_W'(FIFO_DEPTH));
   assign imem_addr = fetch_pc;
   assign handshake = imem_req && imem_gnt;

   assign q_push      = imem_rvalid && (drop_cnt == '0) && !e_pc_src && (!q_full || q_pop);
   assign q_push_data = {resp_pc, resp_pc + 32'd4, imem_rdata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC_W;
         resp_pc     <= RESET_PC_W;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (e_pc_src) begin
            fetch_pc <= target_w;
            resp_pc  <= target_w;
            // every word still in flight, including ones already doomed, is now stale
            drop_cnt <= outstanding - CNT_W'(imem_rvalid);
         end else begin
            if (handshake) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (imem_rvalid && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - 1'b1;
            end
            if (q_push) begin
               resp_pc <= resp_pc + 32'd4;
            end
         end
         if (handshake && !imem_rvalid) begin
            outstanding <= outstanding + 1'b1;
         end else if (!handshake && imem_rvalid) begin
            outstanding <= outstanding - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (e_pc_src),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count),
      .empty     (q_empty),
      .full      (q_full)
   );

   assign f_valid       = !q_empty;
   assign f_pc          = q_empty ? '0 : q_head.pc;
   assign f_pc_plus_4   = q_empty ? '0 : q_head.pc_plus_4;
   assign f_instruction = q_empty ? '0 : q_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a PC-stream reference model
module tb_fetch_unit;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        e_pc_src = 1'b0;
   logic [31:0] e_pc_target = '0;
   logic        f_stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        f_valid;
   logic [31:0] f_pc;
   logic [31:0] f_pc_plus_4;
   logic [31:0] f_instruction;

   fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .e_pc_src      (e_pc_src),
      .e_pc_target   (e_pc_target),
      .f_stall       (f_stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .f_valid       (f_valid),
      .f_pc          (f_pc),
      .f_pc_plus_4   (f_pc_plus_4),
      .f_instruction (f_instruction)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pending[$];
   logic [31:0] hs_log[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_consumed = 0;
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] exp_fetch = RST_PC;
   logic [31:0] prev_pc = '0;
   logic [31:0] prev_instr = '0;
   logic        prev_hold = 1'b0;
   int          gnt_pct = 100;
   int          stall_pct = 0;
   int          redir_pct = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic        force_redir = 1'b0;
   logic [31:0] force_target = '0;
   logic        force_stall = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
   endfunction

   function automatic logic [31:0] random_target();
      logic [31:0] t;
      case ($urandom_range(3))
         0:       t = $urandom;
         1:       t = 32'hFFFF_FF00 | (32'($urandom_range(63)) << 2);
         default: t = (32'($urandom_range(1023)) << 2) | 32'($urandom_range(3));
      endcase
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_cfg(input int g, input int s, input int r, input int lmin, input int lmax);
      gnt_pct   = g;
      stall_pct = s;
      redir_pct = r;
      lat_min   = lmin;
      lat_max   = lmax;
   endtask

   task automatic model();
      if (prev_hold) begin
         chk("hold_valid", 32'(f_valid), 32'd1);
         chk("hold_pc", f_pc, prev_pc);
         chk("hold_instr", f_instruction, prev_instr);
      end
      if (imem_req && imem_gnt) begin
         chk("req_addr", imem_addr, exp_fetch);
         hs_log.push_back(imem_addr);
         pending.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
         exp_fetch = exp_fetch + 32'd4;
         chk("credit", 32'(pending.size() <= DEPTH), 32'd1);
      end
      if (imem_rvalid) begin
         void'(pending.pop_front());
      end
      if (e_pc_src) begin
         chk("redir_req", 32'(imem_req), 32'd0);
         exp_pc    = e_pc_target & ~32'd3;
         exp_fetch = exp_pc;
         hs_log.delete();
      end else if (f_valid && !f_stall) begin
         chk("pc", f_pc, exp_pc);
         chk("pc4", f_pc_plus_4, exp_pc + 32'd4);
         chk("instr", f_instruction, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_consumed++;
      end
      prev_hold  = f_valid && f_stall && !e_pc_src;
      prev_pc    = f_pc;
      prev_instr = f_instruction;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      if (pending.size() > 0 && pending[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pending[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      f_stall = force_stall || ($urandom_range(99) < stall_pct);
      if (force_redir) begin
         e_pc_src    = 1'b1;
         e_pc_target = force_target;
         force_redir = 1'b0;
      end else begin
         e_pc_src    = ($urandom_range(99) < redir_pct);
         e_pc_target = random_target();
      end
      @(negedge clk);
      model();
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      e_pc_src    = 1'b0;
      f_stall     = 1'b0;
      pending.delete();
      hs_log.delete();
      exp_pc    = RST_PC;
      exp_fetch = RST_PC;
      prev_hold = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      force_redir  = 1'b1;
      force_target = t;
      step();
   endtask

   task automatic wait_valid(input string tag, input logic [31:0] pc);
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (f_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_pc"}, f_pc, pc);
         chk({tag, "_instr"}, f_instruction, mem_word(pc));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(f_valid), 32'd0);
      chk("rst_pc", f_pc, 32'd0);
      chk("rst_pc4", f_pc_plus_4, 32'd0);
      chk("rst_instr", f_instruction, 32'd0);
      do_reset();

      set_cfg(100, 0, 0, 1, 1);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("b_req", 32'(imem_req), 32'd1);
         chk("b_addr", imem_addr, 32'(4 * k));
         chk("b_valid", 32'(f_valid), 32'(k >= 2));
         if (k >= 2) chk("b_pc", f_pc, 32'(4 * (k - 2)));
      end

      force_stall = 1'b1;
      repeat (5) step();
      chk("c_req_blocked", 32'(imem_req), 32'd0);
      force_stall = 1'b0;
      repeat (10) step();

      set_cfg(100, 0, 0, 3, 3);
      for (int i = 0; i < 20; i++) begin
         step();
         if (pending.size() == 2) break;
      end
      chk("d_inflight", 32'(pending.size()), 32'd2);
      redirect_to(32'h0000_0100);
      wait_valid("d", 32'h0000_0100);
      repeat (6) step();

      set_cfg(100, 0, 0, 1, 1);
      repeat (4) step();
      redirect_to(32'h0000_2000);
      wait_valid("e", 32'h0000_2000);
      set_cfg(100, 0, 0, 2, 2);
      repeat (4) step();
      redirect_to(32'h0000_3000);
      redirect_to(32'h0000_4002);
      wait_valid("e2", 32'h0000_4000);

      set_cfg(100, 0, 0, 1, 1);
      redirect_to(32'hFFFF_FFF8);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (f_valid && f_pc == 32'hFFFF_FFFC) begin
            chk("f_wrap_p4", f_pc_plus_4, 32'd0);
            seen = 1'b1;
         end
      end
      chk("f_seen", 32'(seen), 32'd1);
      chk("f_hs_cnt", 32'(hs_log.size() >= 3), 32'd1);
      if (hs_log.size() >= 3) begin
         chk("f_addr0", hs_log[0], 32'hFFFF_FFF8);
         chk("f_addr1", hs_log[1], 32'hFFFF_FFFC);
         chk("f_addr2", hs_log[2], 32'h0000_0000);
      end

      repeat (5) step();
      #1 reset_n = 1'b0;
      #1;
      chk("g_req", 32'(imem_req), 32'd0);
      chk("g_valid", 32'(f_valid), 32'd0);
      chk("g_pc", f_pc, 32'd0);
      chk("g_pc4", f_pc_plus_4, 32'd0);
      chk("g_instr", f_instruction, 32'd0);
      do_reset();
      step();
      chk("g_first_req", 32'(imem_req), 32'd1);
      chk("g_first_addr", imem_addr, RST_PC);
      repeat (10) step();

      for (int blk = 0; blk < 8; blk++) begin
         set_cfg(int'($urandom_range(100, 30)), int'($urandom_range(60)),
                 int'($urandom_range(6)), 1, int'($urandom_range(4, 1)));
         repeat (500) step();
      end
      chk("live", 32'(n_consumed > 300), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
